// File: rtl/change_det_mc.sv
// Multi-channel change detector with mode filtering, sticky pend/ovr flags and a combined irq.
// Define CHANGE_DET_DEBOUNCE_EN to build the STABLE-sample debounce filter; otherwise every change commits at once.
module change_det_mc #(
  parameter int unsigned WID    = 8,
  parameter int unsigned CHN    = 4,
  parameter int unsigned STABLE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic [CHN*WID-1:0] i,
  input  logic [2*CHN-1:0]   mode,
  input  logic [CHN-1:0]     ack,
  output logic [CHN*WID-1:0] hold_o,
  output logic [CHN-1:0]     pend,
  output logic [CHN-1:0]     ovr,
  output logic               irq
);

  typedef enum logic [1:0] {
    MODE_ANY  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_OFF  = 2'b11
  } mode_e;

  if (STABLE < 1) begin : g_bad_stable
    $error("change_det_mc: STABLE must be at least 1");
  end

  for (genvar c = 0; c < CHN; c++) begin : g_ch
    logic [WID-1:0] x;
    logic [WID-1:0] hold;
    logic           commit;
    logic           rise;
    logic           fall;
    logic           evt;
    logic           pend_q;
    logic           ovr_q;
    mode_e          m;

    assign x = i[c*WID +: WID];
    assign m = mode_e'(mode[2*c +: 2]);

`ifdef CHANGE_DET_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(STABLE + 1);
    localparam logic [CW-1:0] STB = CW'(STABLE);

    logic [WID-1:0] cand;
    logic [WID-1:0] cand_n;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_n;
    logic [CW-1:0]  cnt_inc;

    assign cnt_inc = cnt + CW'(1);

    // A return to hold zeroes cnt but keeps cand, so resuming cand restarts at 1.
    always_comb begin
      cand_n = cand;
      cnt_n  = cnt;
      commit = 1'b0;
      if (ce) begin
        if (x == hold) begin
          cnt_n = '0;
        end else if (x != cand) begin
          cand_n = x;
          cnt_n  = CW'(1);
          commit = (STABLE == 1);
        end else begin
          cnt_n  = cnt_inc;
          commit = (cnt_inc == STB);
        end
        if (commit) cnt_n = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cand <= x;
        cnt  <= '0;
      end else begin
        cand <= cand_n;
        cnt  <= cnt_n;
      end
    end
`else
    assign commit = ce && (x != hold);
`endif

    always_comb begin
      rise = |(x & ~hold);
      fall = |(~x & hold);
      evt  = 1'b0;
      if (commit) begin
        unique case (m)
          MODE_ANY:  evt = 1'b1;
          MODE_RISE: evt = rise;
          MODE_FALL: evt = fall;
          MODE_OFF:  evt = 1'b0;
          default:   evt = 1'b0;
        endcase
      end
    end

    // Event beats a same-edge ack for pend; ack always clears ovr.
    always_ff @(posedge clk) begin
      if (rst) begin
        hold   <= x;
        pend_q <= 1'b0;
        ovr_q  <= 1'b0;
      end else begin
        if (commit) hold <= x;
        pend_q <= evt | (pend_q & ~ack[c]);
        ovr_q  <= ~ack[c] & (ovr_q | (evt & pend_q));
      end
    end

    assign hold_o[c*WID +: WID] = hold;
    assign pend[c]              = pend_q;
    assign ovr[c]               = ovr_q;
  end

  assign irq = |pend;

endmodule
